// File: rtl/da_fir_pkg.sv
// Shared types and width helpers for the distributed-arithmetic FIR engine.
package da_fir_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int power(int base, int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * base;
    return r;
  endfunction

  // Keeps the partition select at least one bit wide when there is a single partition.
  function automatic int part_width(int partition);
    return (partition > 1) ? $clog2(partition) : 1;
  endfunction

  function automatic int acc_width(int lut_w, int opsize, int partition);
    return lut_w + opsize + $clog2(partition) + 1;
  endfunction

endpackage

// File: rtl/da_fir_engine_if.sv
// Sample/result handshakes and LUT write port of the DA FIR engine.
interface da_fir_engine_if
  import da_fir_pkg::*;
#(
  parameter int OPSIZE    = 12,
  parameter int ORDER     = 6,
  parameter int PARTITION = 2,
  parameter int LUT_W     = 16
);
  localparam int TPP    = ORDER / PARTITION;
  localparam int PART_W = part_width(PARTITION);
  localparam int ACC_W  = acc_width(LUT_W, OPSIZE, PARTITION);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [OPSIZE-1:0] x;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  y;
  logic                     lut_we;
  logic [PART_W-1:0]        lut_part;
  logic [TPP-1:0]           lut_addr;
  logic signed [LUT_W-1:0]  lut_wdata;

  modport master (
    output in_valid, x, out_ready, lut_we, lut_part, lut_addr, lut_wdata,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x, out_ready, lut_we, lut_part, lut_addr, lut_wdata,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/da_lut.sv
// One partition's coefficient subset-sum table: single write port, BAAT combinational reads.
module da_lut
  import da_fir_pkg::*;
#(
  parameter int TPP   = 3,
  parameter int LUT_W = 16,
  parameter int BAAT  = 3
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [TPP-1:0]              waddr_i,
  input  logic [LUT_W-1:0]            wdata_i,
  input  logic [BAAT-1:0][TPP-1:0]    raddr_i,
  output logic [BAAT-1:0][LUT_W-1:0]  rdata_o
);
  localparam int DEPTH = power(2, TPP);

  // Contents survive reset; they are reloaded by software, not by rst_n.
  logic [LUT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_comb begin
    for (int b = 0; b < BAAT; b++) rdata_o[b] = mem_q[raddr_i[b]];
  end
endmodule

// File: rtl/da_fir_engine.sv
// Distributed-arithmetic FIR: BAAT sample bits per cycle, MSB slice first, PARTITION LUTs.
module da_fir_engine
  import da_fir_pkg::*;
#(
  parameter int OPSIZE    = 12,
  parameter int ORDER     = 6,
  parameter int BAAT      = 3,
  parameter int PARTITION = 2,
  parameter int LUT_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  da_fir_engine_if.slave  bus
);
  localparam int NCYC   = OPSIZE / BAAT;
  localparam int TPP    = ORDER / PARTITION;
  localparam int KW     = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int BW     = (OPSIZE > 1) ? $clog2(OPSIZE) : 1;
  localparam int PART_W = part_width(PARTITION);
  localparam int ACC_W  = acc_width(LUT_W, OPSIZE, PARTITION);

  state_t                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, y_q, y_d;
  logic signed [ACC_W-1:0]  p_sum, acc_next;
  logic signed [OPSIZE-1:0] taps_q [ORDER];
  logic                     shift_en;

  logic [PARTITION-1:0][BAAT-1:0][TPP-1:0]   lut_raddr;
  logic [PARTITION-1:0][BAAT-1:0][LUT_W-1:0] lut_rdata;

  // Sign-extend one LUT read, weight it by 2^b, and negate it for the sample's sign bit.
  function automatic logic signed [ACC_W-1:0] slice_term(logic [LUT_W-1:0] raw, int b,
                                                         logic neg);
    logic signed [ACC_W-1:0] t;
    t = {{(ACC_W-LUT_W){raw[LUT_W-1]}}, raw};
    t = t <<< b;
    return neg ? -t : t;
  endfunction

  for (genvar p = 0; p < PARTITION; p++) begin : g_lut
    da_lut #(.TPP(TPP), .LUT_W(LUT_W), .BAAT(BAAT)) u_lut (
      .clk     (clk),
      .we_i    (bus.lut_we && (state_q == IDLE) && (bus.lut_part == PART_W'(p))),
      .waddr_i (bus.lut_addr),
      .wdata_i (bus.lut_wdata),
      .raddr_i (lut_raddr[p]),
      .rdata_o (lut_rdata[p])
    );
  end

  always_comb begin
    logic [BW-1:0] bidx;
    lut_raddr = '0;
    bidx      = '0;
    for (int b = 0; b < BAAT; b++) begin
      bidx = BW'(int'(k_q) * BAAT + b);
      for (int p = 0; p < PARTITION; p++)
        for (int i = 0; i < TPP; i++)
          lut_raddr[p][b][i] = taps_q[p*TPP+i][bidx];
    end
  end

  always_comb begin
    p_sum = '0;
    for (int p = 0; p < PARTITION; p++)
      for (int b = 0; b < BAAT; b++)
        p_sum = p_sum + slice_term(lut_rdata[p][b], b,
                                   (int'(k_q) * BAAT + b) == (OPSIZE - 1));
  end

  assign acc_next = (acc_q <<< BAAT) + p_sum;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    y_d      = y_q;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: if (bus.in_valid) begin
        shift_en = 1'b1;
        acc_d    = '0;
        k_d      = KW'(NCYC - 1);
        state_d  = RUN;
      end
      RUN: begin
        acc_d = acc_next;
        k_d   = k_q - KW'(1);
        if (k_q == '0) begin
          y_d     = acc_next;
          state_d = DONE;
        end
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      for (int t = 0; t < ORDER; t++) taps_q[t] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      if (shift_en) begin
        taps_q[0] <= bus.x;
        for (int t = 1; t < ORDER; t++) taps_q[t] <= taps_q[t-1];
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.y         = y_q;
endmodule

// File: tb/tb_da_fir_engine.sv
// Bench for da_fir_engine: bit-level DA reference model plus directed literal cases and random traffic.
module tb_da_fir_engine;
  localparam int OPSIZE    = 12;
  localparam int ORDER     = 6;
  localparam int BAAT      = 3;
  localparam int PARTITION = 2;
  localparam int LUT_W     = 16;
  localparam int TPP       = ORDER / PARTITION;
  localparam int NCYC      = OPSIZE / BAAT;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  da_fir_engine_if #(.OPSIZE(OPSIZE), .ORDER(ORDER), .PARTITION(PARTITION), .LUT_W(LUT_W)) bus ();

  da_fir_engine #(.OPSIZE(OPSIZE), .ORDER(ORDER), .BAAT(BAAT), .PARTITION(PARTITION),
                  .LUT_W(LUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
  endtask

  // Reference: phase 0 = accepting, 1 = computing, 2 = holding a result.
  longint                   lut_m [PARTITION][2**TPP];
  logic signed [OPSIZE-1:0] m_taps [ORDER];
  int                       m_phase, m_wait;
  longint                   m_y, m_pend;

  // y = sum over sample bit positions j of weight(j) * sum_p LUT_p[bit j of that partition's taps].
  function automatic longint model_y();
    longint s, w;
    int a;
    s = 0;
    for (int j = 0; j < OPSIZE; j++) begin
      w = (j == OPSIZE - 1) ? -(longint'(1) <<< j) : (longint'(1) <<< j);
      for (int p = 0; p < PARTITION; p++) begin
        a = 0;
        for (int i = 0; i < TPP; i++) if (m_taps[p*TPP+i][j]) a = a | (1 << i);
        s = s + w * lut_m[p][a];
      end
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_wait  = 0;
      m_y     = 0;
      for (int t = 0; t < ORDER; t++) m_taps[t] = '0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.lut_we && int'(bus.lut_part) < PARTITION)
            lut_m[bus.lut_part][bus.lut_addr] = longint'(bus.lut_wdata);
          if (bus.in_valid) begin
            for (int t = ORDER - 1; t > 0; t--) m_taps[t] = m_taps[t-1];
            m_taps[0] = bus.x;
            m_pend  = model_y();
            m_wait  = NCYC;
            m_phase = 1;
          end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) begin
            m_y     = m_pend;
            m_phase = 2;
          end
        end
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", longint'(bus.out_valid), 0);
      check("rst_in_ready", longint'(bus.in_ready), 1);
      check("rst_y", longint'(bus.y), 0);
    end else begin
      check("in_ready", longint'(bus.in_ready), longint'(m_phase == 0));
      check("out_valid", longint'(bus.out_valid), longint'(m_phase == 2));
      check("y", longint'(bus.y), m_y);
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 0, 1);
  endtask

  // Offer one sample and wait for its result; leaves the engine holding it.
  task automatic send(input logic signed [OPSIZE-1:0] xv, input bit wr_run,
                      output longint yv, output int lat);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.x        = xv;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x        = OPSIZE'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      bus.lut_we = 1'b0;
      if (wr_run && lat == 1) begin
        bus.lut_we    = 1'b1;
        bus.lut_part  = '0;
        bus.lut_addr  = TPP'(1);
        bus.lut_wdata = LUT_W'(100);
      end
    end
    bus.lut_we = 1'b0;
    if (!bus.out_valid) check("out_valid_timeout", 0, 1);
    yv = longint'(bus.y);
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic xfer(input string name, input logic signed [OPSIZE-1:0] xv,
                      input longint exp, input bit chk);
    longint yv;
    int lat;
    send(xv, 1'b0, yv, lat);
    if (chk) begin
      check({name, "_y"}, yv, exp);
      check({name, "_latency"}, lat, NCYC);
    end
    release_result();
  endtask

  task automatic lut_write(input int p, input int a, input longint v);
    bus.lut_we    = 1'b1;
    bus.lut_part  = 1'(p);
    bus.lut_addr  = TPP'(a);
    bus.lut_wdata = LUT_W'(v);
    @(negedge clk);
    bus.lut_we = 1'b0;
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint yv, v;
    int lat;
    longint imp_exp [7];
    imp_exp = '{1, 2, 3, 4, 5, 6, 0};

    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.out_ready = 1'b0;
    bus.lut_we    = 1'b0;
    bus.lut_part  = '0;
    bus.lut_addr  = '0;
    bus.lut_wdata = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Load subset sums of h = [1..6].
    for (int p = 0; p < PARTITION; p++)
      for (int a = 0; a < 2**TPP; a++) begin
        v = 0;
        for (int i = 0; i < TPP; i++) if ((a >> i) & 1) v = v + (p * TPP + i + 1);
        lut_write(p, a, v);
      end

    for (int n = 0; n < 7; n++)
      xfer($sformatf("impulse%0d", n), (n == 0) ? 12'sd1 : 12'sd0, imp_exp[n], 1'b1);

    pulse_reset();
    xfer("negfs", -12'sd2048, -2048, 1'b1);
    xfer("negfs_shift", 12'sd0, -4096, 1'b1);

    for (int n = 0; n < 6; n++) xfer("maxpos", 12'sd2047, 42987, n == 5);
    for (int n = 0; n < 6; n++) xfer("maxneg", -12'sd2048, -43008, n == 5);

    pulse_reset();
    send(12'sd5, 1'b0, yv, lat);
    check("bp_y", yv, 5);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.x        = 12'sd123;
      @(negedge clk);
      check("bp_hold_y", longint'(bus.y), 5);
      check("bp_hold_valid", longint'(bus.out_valid), 1);
      check("bp_hold_ready", longint'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    release_result();
    check("bp_release_idle", longint'(bus.in_ready), 1);
    xfer("bp_not_shifted", 12'sd0, 10, 1'b1);

    pulse_reset();
    send(12'sd1, 1'b1, yv, lat);
    check("lutwr_run_ignored", yv, 1);
    release_result();
    lut_write(0, 1, 100);
    pulse_reset();
    xfer("lutwr_idle", 12'sd1, 100, 1'b1);
    lut_write(0, 1, 1);

    pulse_reset();
    xfer("pre_rst_fill", 12'sd7, 7, 1'b1);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.x        = 12'sd9;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_rst_valid", longint'(bus.out_valid), 0);
    check("midrun_rst_y", longint'(bus.y), 0);
    check("midrun_rst_ready", longint'(bus.in_ready), 1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    xfer("after_rst", 12'sd1, 1, 1'b1);

    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = 1'($urandom);
      bus.x         = OPSIZE'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.lut_we    = ($urandom_range(0, 7) == 0);
      bus.lut_part  = 1'($urandom);
      bus.lut_addr  = TPP'($urandom);
      bus.lut_wdata = LUT_W'($urandom);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.lut_we    = 1'b0;
    bus.out_ready = 1'b1;
    repeat (NCYC + 4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
